dpopt_sop_pipe: RTL and testbench
=================================

# dpopt_sop_pipe

Parametrised, pipelined sum-of-products / sum-of-absolute-differences engine with busy/vld handshakes on both sides. It generalises the fixed eight-input datapath-optimisation DUT to NUM_PAIRS operand pairs of DATA_W bits. It adds a per-beat mode select, multi-beat accumulation and a credit-protected output FIFO. It sits between an upstream busy/vld producer and a downstream busy/vld consumer.

## Interface
- NUM_PAIRS, 4, operand pairs per beat (1..16)
- DATA_W, 8, unsigned operand width (2..16)
- OUT_W, 32, result/accumulator width; must be ≥ R = 2*DATA_W + clog2(NUM_PAIRS)
- FIFO_DEPTH, 4, output FIFO entries (2..16; 4 or more gives full throughput)
- clk  in  1  single clock, rising edge
- rst  in  1  reset is synchronous and active-high
- din_vld  in  1  input beat valid
- din_busy  out  1  block cannot accept; a beat transfers on an edge where din_vld=1 and din_busy=0
- din_data  in  2*NUM_PAIRS*DATA_W  operand lanes; pair i = (lane 2i, lane 2i+1); lane k = bits [k*DATA_W +: DATA_W]
- din_mode  in  1  0 = sum of products a*b; 1 = sum of |a−b|
- din_acc  in  1  1 = add into accumulator, emit nothing; 0 = emit accumulator+beat, clear accumulator
- dout_vld  out  1  output beat valid
- dout_busy  in  1  consumer stall; a beat pops on an edge where dout_vld=1 and dout_busy=0
- dout_data  out  OUT_W  result
- dout_sat  out  1  result saturated

## Operation
- S1 (edge after accept): per-pair term registered: a*b (2*DATA_W bits) or |a−b| (DATA_W bits, zero-extended). Beat's acc flag travels with it.
- S2 (next edge): adder tree sums the terms to R bits. The sum is added to the accumulator in OUT_W+1 bits.
  - If the sum exceeds 2^OUT_W−1, the value clamps to 2^OUT_W−1 and a sat flag is set.
  - The sat flag is sticky across an accumulation group.
- acc=1 beat: the accumulator and sticky sat are updated. No FIFO write.
- acc=0 beat: {value, sat} written to FIFO. Accumulator and sticky sat then clear to 0.
- Modes may be mixed within one accumulation group. The terms simply add.
- FIFO: in-order, no drop. dout_data/dout_sat come from the head entry.
- Credit rule: din_busy = rst OR (fifo_occupancy + beats_in_S1_S2 ≥ FIFO_DEPTH).
  - Both terms are registered counts; the current cycle's pop is not credited.
  - The pipeline therefore never stalls, and the FIFO never overflows.
  - acc=1 beats count as in-flight while they are in S1/S2.
- Simultaneous FIFO push and pop at any occupancy, including empty→push/pop bypass-free and full: both take effect, occupancy unchanged.

## Timing
- Reset values, held while rst=1:
  - din_busy=1, dout_vld=0, dout_data=0, dout_sat=0
  - accumulator=0, FIFO empty, S1/S2 empty
- First cycle after rst deasserts: din_busy=0.
- Reset mid-operation discards all in-flight beats, FIFO contents and the partial accumulation. No stale output appears after reset.
- Latency: a beat accepted at edge E0 enters S1 at E1 and is written to the FIFO at E2. dout_vld=1 in the cycle after E2 when the FIFO was empty.
- Throughput: 1 beat/cycle sustained when dout_busy=0 and FIFO_DEPTH ≥ 4.
- While dout_vld=1 and dout_busy=1: dout_data and dout_sat hold stable.
- dout_vld falls only after the last entry pops.
- din_busy may toggle every cycle. The upstream may hold or change din_data while din_busy=1.

## Test plan
- Defaults. One acc=0, mode 0 beat with pairs (1,2),(3,4),(5,6),(7,8) → dout_data=100, dout_sat=0. dout_vld rises 2 cycles after acceptance.
- Mode 1 beat with pairs (10,3),(3,10),(255,0),(0,0) → dout_data=269.
- Three acc=1 mode 0 beats with all lanes 255, then one acc=0 beat, same data → exactly one output, dout_data=1040400.
  - A following acc=0 beat with pairs (1,1),(0,0),(0,0),(0,0) → dout_data=1 (accumulator cleared).
- Hold dout_busy=1 and offer 10 back-to-back acc=0 beats → exactly 4 accepted, then din_busy=1 continuously.
  - Release dout_busy → 4 results in order; remaining beats accepted; no loss or duplication.
- OUT_W=18. One acc=1 beat plus one acc=0 beat, both all-255 mode 0 (2×260100) → dout_data=262143, dout_sat=1.
  - A next single beat of 100 → dout_sat=0.
- Accept one acc=1 beat, assert rst for 1 cycle while the FIFO holds 2 entries, then send an acc=0 beat equal to 100 → dout_vld=0 during and after reset. The only output is 100.

Source files
------------

// File: rtl/dpopt_sop_pipe.sv
// Pipelined sum-of-products / sum-of-absolute-differences engine with
// multi-beat accumulation, saturation and a credit-protected output FIFO.
module dpopt_sop_pipe #(
  parameter int NUM_PAIRS  = 4,
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              din_vld,
  output logic                              din_busy,
  input  logic [2*NUM_PAIRS*DATA_W-1:0]     din_data,
  input  logic                              din_mode,
  input  logic                              din_acc,
  output logic                              dout_vld,
  input  logic                              dout_busy,
  output logic [OUT_W-1:0]                  dout_data,
  output logic                              dout_sat
);

  localparam int TW = 2*DATA_W;
  localparam int R  = 2*DATA_W + $clog2(NUM_PAIRS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 3);
  localparam logic [OUT_W:0] MAX_VAL = {1'b0, {OUT_W{1'b1}}};

  logic                          w_accept;
  logic                          r_s0_vld, r_s0_mode, r_s0_acc;
  logic [2*NUM_PAIRS*DATA_W-1:0] r_s0_data;
  logic                          r_s1_vld, r_s1_acc;
  logic [TW-1:0]                 r_s1_term [NUM_PAIRS];
  logic [TW-1:0]                 w_term    [NUM_PAIRS];
  logic [R-1:0]                  w_sum;
  logic [OUT_W:0]                w_total;
  logic                          w_ovf, w_sat, w_push, w_pop;
  logic [OUT_W-1:0]              w_val;
  logic [OUT_W-1:0]              r_acc;
  logic                          r_acc_sat;
  logic [OUT_W-1:0]              r_mem_data [FIFO_DEPTH];
  logic                          r_mem_sat  [FIFO_DEPTH];
  logic [PW-1:0]                 r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                 r_count;
  logic [CW-1:0]                 w_credit;

  // Occupancy plus beats still in the pipe; a pop in this cycle is not credited.
  assign w_credit = r_count + CW'(r_s0_vld) + CW'(r_s1_vld);
  assign din_busy = rst | (w_credit >= CW'(FIFO_DEPTH));
  assign w_accept = din_vld & ~din_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_vld  <= 1'b0;
      r_s0_mode <= 1'b0;
      r_s0_acc  <= 1'b0;
    end else begin
      r_s0_vld <= w_accept;
      if (w_accept) begin
        r_s0_mode <= din_mode;
        r_s0_acc  <= din_acc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_s0_data <= din_data;
  end

  for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
    logic [DATA_W-1:0] w_a, w_b;
    assign w_a = r_s0_data[(2*gi)*DATA_W +: DATA_W];
    assign w_b = r_s0_data[(2*gi+1)*DATA_W +: DATA_W];
    assign w_term[gi] = r_s0_mode ? TW'((w_a >= w_b) ? (w_a - w_b) : (w_b - w_a))
                                  : TW'(w_a) * TW'(w_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_acc <= 1'b0;
    end else begin
      r_s1_vld <= r_s0_vld;
      r_s1_acc <= r_s0_acc;
    end
    for (int i = 0; i < NUM_PAIRS; i++) r_s1_term[i] <= w_term[i];
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_PAIRS; i++) w_sum = w_sum + R'(r_s1_term[i]);
  end

  // One extra bit catches the carry so the clamp decision is exact.
  assign w_total = {1'b0, r_acc} + (OUT_W+1)'(w_sum);
  assign w_ovf   = (w_total > MAX_VAL);
  assign w_val   = w_ovf ? {OUT_W{1'b1}} : w_total[OUT_W-1:0];
  assign w_sat   = r_acc_sat | w_ovf;
  assign w_push  = r_s1_vld & ~r_s1_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_acc_sat <= 1'b0;
    end else if (r_s1_vld) begin
      if (r_s1_acc) begin
        r_acc     <= w_val;
        r_acc_sat <= w_sat;
      end else begin
        r_acc     <= '0;
        r_acc_sat <= 1'b0;
      end
    end
  end

  assign dout_vld  = ~rst & (r_count != '0);
  assign w_pop     = dout_vld & ~dout_busy;
  assign dout_data = dout_vld ? r_mem_data[r_rd_ptr] : '0;
  assign dout_sat  = dout_vld ? r_mem_sat[r_rd_ptr]  : 1'b0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_val;
      r_mem_sat[r_wr_ptr]  <= w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dpopt_sop_pipe.sv
// Directed bench for dpopt_sop_pipe: default instance plus an OUT_W=18 instance
// for saturation; expected results are queued on accept and checked on output.
module tb_dpopt_sop_pipe;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int LW = 2*NP*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          a_din_vld, a_din_busy, a_din_mode, a_din_acc;
  logic [LW-1:0] a_din_data;
  logic          a_dout_vld, a_dout_busy, a_dout_sat;
  logic [31:0]   a_dout_data;
  logic          b_din_vld, b_din_busy, b_din_mode, b_din_acc;
  logic [LW-1:0] b_din_data;
  logic          b_dout_vld, b_dout_busy, b_dout_sat;
  logic [17:0]   b_dout_data;

  dpopt_sop_pipe u_dut_a (
    .clk(clk), .rst(rst),
    .din_vld(a_din_vld), .din_busy(a_din_busy), .din_data(a_din_data),
    .din_mode(a_din_mode), .din_acc(a_din_acc),
    .dout_vld(a_dout_vld), .dout_busy(a_dout_busy),
    .dout_data(a_dout_data), .dout_sat(a_dout_sat)
  );

  dpopt_sop_pipe #(.OUT_W(18)) u_dut_b (
    .clk(clk), .rst(rst),
    .din_vld(b_din_vld), .din_busy(b_din_busy), .din_data(b_din_data),
    .din_mode(b_din_mode), .din_acc(b_din_acc),
    .dout_vld(b_dout_vld), .dout_busy(b_dout_busy),
    .dout_data(b_dout_data), .dout_sat(b_dout_sat)
  );

  int     errors = 0;
  int     checks = 0;
  int     acc_cnt_a = 0;
  int     acc_cnt_b = 0;
  longint qa_data[$];
  bit     qa_sat[$];
  longint qb_data[$];
  bit     qb_sat[$];
  longint acc_a = 0, acc_b = 0;
  bit     sat_a = 0, sat_b = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pk(input int p0, input int p1, input int p2, input int p3,
                                       input int p4, input int p5, input int p6, input int p7);
    logic [LW-1:0] d;
    d = {8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    return d;
  endfunction

  function automatic longint beat_sum(input logic [LW-1:0] d, input logic mode);
    longint s, a, b;
    s = 0;
    for (int i = 0; i < NP; i++) begin
      a = longint'(d[(2*i)*DW +: DW]);
      b = longint'(d[(2*i+1)*DW +: DW]);
      if (mode) s += (a > b) ? (a - b) : (b - a);
      else      s += a * b;
    end
    return s;
  endfunction

  task automatic model(input bit inst, input logic [LW-1:0] d, input logic mode, input logic acc);
    longint t, mx;
    bit ov, s;
    mx = inst ? 64'd262143 : 64'd4294967295;
    t  = (inst ? acc_b : acc_a) + beat_sum(d, mode);
    ov = (t > mx);
    if (ov) t = mx;
    s = (inst ? sat_b : sat_a) | ov;
    if (acc) begin
      if (inst) begin acc_b = t; sat_b = s; end
      else      begin acc_a = t; sat_a = s; end
    end else if (inst) begin
      qb_data.push_back(t); qb_sat.push_back(s); acc_b = 0; sat_b = 0;
    end else begin
      qa_data.push_back(t); qa_sat.push_back(s); acc_a = 0; sat_a = 0;
    end
  endtask

  // Runs at the negedge: compare the head output, then record accepted beats.
  task automatic mon();
    if (rst) begin
      chk("rst_vld_a", a_dout_vld, 0);
      chk("rst_busy_a", a_din_busy, 1);
      chk("rst_vld_b", b_dout_vld, 0);
      qa_data.delete(); qa_sat.delete(); qb_data.delete(); qb_sat.delete();
      acc_a = 0; sat_a = 0; acc_b = 0; sat_b = 0;
    end else begin
      if (a_dout_vld) begin
        if (qa_data.size() == 0) chk("a_unexpected_out", a_dout_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("a_data", a_dout_data, qa_data[0]);
          chk("a_sat", a_dout_sat, qa_sat[0]);
          if (!a_dout_busy) begin void'(qa_data.pop_front()); void'(qa_sat.pop_front()); end
        end
      end
      if (b_dout_vld) begin
        if (qb_data.size() == 0) chk("b_unexpected_out", b_dout_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("b_data", b_dout_data, qb_data[0]);
          chk("b_sat", b_dout_sat, qb_sat[0]);
          if (!b_dout_busy) begin void'(qb_data.pop_front()); void'(qb_sat.pop_front()); end
        end
      end
      if (a_din_vld && !a_din_busy) begin
        acc_cnt_a++;
        model(1'b0, a_din_data, a_din_mode, a_din_acc);
      end
      if (b_din_vld && !b_din_busy) begin
        acc_cnt_b++;
        model(1'b1, b_din_data, b_din_mode, b_din_acc);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [LW-1:0] d, input logic mode, input logic acc);
    int c0, n;
    c0 = acc_cnt_a; n = 0;
    a_din_data = d; a_din_mode = mode; a_din_acc = acc; a_din_vld = 1'b1;
    while (acc_cnt_a == c0 && n < 100) begin step(); n++; end
    a_din_vld = 1'b0;
    if (acc_cnt_a == c0) chk("a_send_timeout", 0, 1);
  endtask

  task automatic send_b(input logic [LW-1:0] d, input logic mode, input logic acc);
    int c0, n;
    c0 = acc_cnt_b; n = 0;
    b_din_data = d; b_din_mode = mode; b_din_acc = acc; b_din_vld = 1'b1;
    while (acc_cnt_b == c0 && n < 100) begin step(); n++; end
    b_din_vld = 1'b0;
    if (acc_cnt_b == c0) chk("b_send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa_data.size() != 0 || qb_data.size() != 0) && n < 200) begin step(); n++; end
    chk("drain_a", qa_data.size(), 0);
    chk("drain_b", qb_data.size(), 0);
    repeat (4) step();
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    a_din_vld = 0; a_din_mode = 0; a_din_acc = 0; a_din_data = '0; a_dout_busy = 0;
    b_din_vld = 0; b_din_mode = 0; b_din_acc = 0; b_din_data = '0; b_dout_busy = 0;
    repeat (3) step();
    chk("rst_dout_data", a_dout_data, 0);
    chk("rst_dout_sat", a_dout_sat, 0);
    chk("rst_din_busy", a_din_busy, 1);
    rst = 1'b0;
    #1;
    chk("post_rst_busy_a", a_din_busy, 0);
    chk("post_rst_busy_b", b_din_busy, 0);

    // Single SOP beat and its latency
    a_din_data = pk(1, 2, 3, 4, 5, 6, 7, 8); a_din_mode = 0; a_din_acc = 0; a_din_vld = 1;
    step();
    a_din_vld = 0;
    step();
    chk("lat_vld_e1", a_dout_vld, 0);
    step();
    chk("lat_vld_e2", a_dout_vld, 1);
    chk("t1_data", a_dout_data, 100);
    chk("t1_sat", a_dout_sat, 0);
    drain();

    // SAD beat
    send_a(pk(10, 3, 3, 10, 255, 0, 0, 0), 1'b1, 1'b0);
    drain();

    // Accumulation group, then a fresh group
    repeat (3) send_a(pk(255, 255, 255, 255, 255, 255, 255, 255), 1'b0, 1'b1);
    send_a(pk(255, 255, 255, 255, 255, 255, 255, 255), 1'b0, 1'b0);
    send_a(pk(1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    drain();

    // Back-pressure: only FIFO_DEPTH beats get in while the consumer stalls
    base = acc_cnt_a;
    a_dout_busy = 1; a_din_mode = 0; a_din_acc = 0; a_din_vld = 1;
    for (int i = 0; i < 12; i++) begin
      a_din_data = pk(acc_cnt_a - base + 1, 1, 0, 0, 0, 0, 0, 0);
      step();
      if (i >= 6) chk("stall_busy", a_din_busy, 1);
    end
    chk("stall_accepted", acc_cnt_a - base, 4);
    a_dout_busy = 0;
    n = 0;
    while (acc_cnt_a - base < 10 && n < 100) begin
      a_din_data = pk(acc_cnt_a - base + 1, 1, 0, 0, 0, 0, 0, 0);
      step();
      n++;
    end
    a_din_vld = 0;
    chk("stall_total_accepted", acc_cnt_a - base, 10);
    drain();

    // Saturation on the narrow instance, then a clean beat
    send_b(pk(255, 255, 255, 255, 255, 255, 255, 255), 1'b0, 1'b1);
    send_b(pk(255, 255, 255, 255, 255, 255, 255, 255), 1'b0, 1'b0);
    send_b(pk(100, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    drain();

    // Reset with FIFO contents and a partial accumulation
    a_dout_busy = 1;
    send_a(pk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 1'b0);
    send_a(pk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 1'b0);
    send_a(pk(9, 9, 9, 9, 9, 9, 9, 9), 1'b0, 1'b1);
    step(); step();
    chk("pre_rst_vld", a_dout_vld, 1);
    rst = 1'b1;
    #1;
    chk("in_rst_vld", a_dout_vld, 0);
    step();
    rst = 1'b0;
    a_dout_busy = 0;
    #1;
    chk("after_rst_busy", a_din_busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_vld", a_dout_vld, 0);
    end
    send_a(pk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 1'b0);
    step(); step();
    chk("rst_final_data", a_dout_data, 100);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
